hack_dmux_stream: RTL
=====================

# hack_dmux_stream

Registered, parametrised N-way demultiplexer with a valid/ready handshake on every port. It routes an input word to one of `WAYS` output channels selected by `in_sel`, or to all channels when broadcast is enabled. Each channel holds one buffered word, so a stalled consumer only blocks traffic addressed to it. The block sits between a single producer and several independently back-pressured consumers in the Hack datapath. It generalises the combinational 1-bit DMux4Way to arbitrary width, channel count and flow control.

## Interface
- `WIDTH`, 16: data word width in bits (≥1).
- `WAYS`, 4: number of output channels; power of two, 2..16.
- `SEL_W`, `$clog2(WAYS)`: selector width; derived, do not override.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `in_valid` input 1: producer offers `in_data`/`in_sel`/`in_bcast`.
- `in_ready` output 1: block accepts this cycle; a transfer occurs when `in_valid & in_ready`.
- `in_data` input WIDTH: word to route.
- `in_sel` input SEL_W: target channel index.
- `in_bcast` input 1: route the word to all channels. Ignored unless `HACK_DMUX_BCAST_EN` is defined.
- `out_valid` output WAYS: bit i set means channel i holds a word.
- `out_ready` input WAYS: consumer i takes the word; a drain occurs when `out_valid[i] & out_ready[i]`.
- `out_data` output WAYS*WIDTH: channel i occupies bits `[i*WIDTH +: WIDTH]`.

## Operation
- Per channel: a one-entry buffer, `full[i]` plus `data[i]`. `out_valid[i] = full[i]`.
- `free[i] = !full[i] | out_ready[i]`. The buffer can take a word this cycle, including a same-cycle drain and refill.
- Unicast (`in_bcast = 0`, or macro absent): `in_ready = free[in_sel]`. It depends combinationally on `in_sel` and `out_ready`, and never on `in_valid`.
- Broadcast (`in_bcast = 1`, macro present): `in_ready = &free`. On transfer, every channel loads `in_data` at once. A broadcast is all-or-nothing; there is never a partial broadcast.
- Channel update priority, per cycle:
  - write (transfer targets i): `full <= 1`, `data <= in_data`;
  - else drain: `full <= 0`, `data <= 0`;
  - else hold.
- `out_data` slice i is always 0 while `out_valid[i] = 0`. This is the Hack DMux convention: unselected outputs read 0.
- While `out_valid[i] & !out_ready[i]`, slice i is stable until drained.
- No reordering issue arises: each channel holds at most one word, and words to one channel leave in acceptance order.
- Channels are fully independent. A stalled channel never blocks a transfer addressed to another channel.

## Timing
- Reset, asynchronous assert and synchronous-to-`clk` release: all `full` = 0, all `data` = 0. The outputs are then `out_valid` = 0, `out_data` = 0, and `in_ready` = 1 for any `in_sel`.
- Reset mid-operation discards buffered words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge k is visible on `out_valid`/`out_data` right after edge k, so a consumer can drain it at edge k+1.
- Throughput: one word per cycle to a single channel is sustained when its `out_ready` is held at 1.
- `in_sel` out of range cannot occur (WAYS is a power of two).

## Configuration
- `HACK_DMUX_BCAST_EN` defined: `in_bcast` is honoured as described in Operation.
- Not defined: `in_bcast` is ignored, and no broadcast logic or all-channel ready reduction is synthesised. Behaviour equals unicast with `in_bcast = 0`.

## Test plan
- Reset check (WIDTH=16, WAYS=4): assert `rst_n = 0` mid-stream with channels full → `out_valid` = 4'b0000 and `out_data` = 0 immediately; after release, `in_ready` = 1.
- Unicast sweep: send 16'hA5A0+i with `in_sel` = i for i = 0..3, all `out_ready` = 1 → each word appears only on channel i one cycle later; the other slices read 0.
- Back-pressure isolation: `out_ready[2] = 0`, send to channel 2 twice → the first word is held stable and `in_ready` = 0 on the second. Meanwhile a send to channel 1 is accepted. Raising `out_ready[2]` → the second word is accepted in the same cycle as the drain.
- Streaming: 8 back-to-back words to channel 3 with `out_ready[3] = 1` → 8 transfers in 8 cycles, in order, with no bubbles.
- Broadcast (macro on): `in_bcast = 1`, `in_data` = 16'h1234, `out_ready[0] = 0` and channel 0 full → `in_ready` = 0 and no channel loads. Once channel 0 is freed → all 4 channels show 16'h1234 together.
- Broadcast (macro off): the same stimulus → only channel `in_sel` receives 16'h1234.

Source files
------------

// File: rtl/hack_dmux_stream.sv
// hack_dmux_stream: registered N-way demultiplexer with a valid/ready handshake
// on the input and on every output channel. Each channel buffers a single word,
// so a stalled consumer only holds up traffic addressed to it. An empty channel
// reads as zero.
//
// Optional feature: define HACK_DMUX_BCAST_EN to honour in_bcast. A broadcast
// loads all channels together, and only when every channel can take the word.
// Without the macro, in_bcast is ignored.
module hack_dmux_stream #(
  parameter int WIDTH = 16,
  parameter int WAYS  = 4,
  parameter int SEL_W = $clog2(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_bcast,
  output logic [WAYS-1:0]       out_valid,
  input  logic [WAYS-1:0]       out_ready,
  output logic [WAYS*WIDTH-1:0] out_data
);

  logic [WAYS-1:0]             full_q, full_d;
  logic [WAYS-1:0][WIDTH-1:0]  data_q, data_d;
  logic [WAYS-1:0]             free;
  logic [WAYS-1:0]             target;
  logic [WAYS-1:0]             wr_en;

  // A channel can take a word if it is empty or is being drained this cycle.
  assign free = ~full_q | out_ready;

`ifdef HACK_DMUX_BCAST_EN
  // Pick the destination channels, and the readiness they need: all channels
  // for a broadcast, otherwise only the selected one.
  always_comb begin
    target = '0;
    if (in_bcast) begin
      target   = '1;
      in_ready = &free;
    end else begin
      target[in_sel] = 1'b1;
      in_ready       = free[in_sel];
    end
  end
`else
  logic unused_bcast;
  assign unused_bcast = in_bcast;

  // Pick the destination channel. Readiness depends only on the selected channel.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    target         = '0;
    target[in_sel] = 1'b1;
    in_ready       = free[in_sel];
  end
`endif

  assign wr_en = target & {WAYS{in_valid & in_ready}};

  // Next state per channel: a write wins over a drain, and a drain clears the word to zero.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int i = 0; i < WAYS; i++) begin
      if (wr_en[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = in_data;
      end else if (full_q[i] && out_ready[i]) begin
        full_d[i] = 1'b0;
        data_d[i] = '0;
      end
    end
  end

  // Channel state registers. Reset discards every buffered word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= '0;
      // NOTE: the data storage is reset too, because an empty channel must read zero from the moment reset is asserted.
      data_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign out_valid = full_q;
  assign out_data  = data_q;

endmodule
